mcse_ahb_multi_requester: RTL

//  N-channel AHB-Lite requester for the MCSE. Round-robin arbitrates payload-wide go/done requests
//  (boot control, firmware loader, key manager, ...) onto one system AHB requester port.

---
 rtl/mcse_ahb_multi_requester.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mcse_ahb_multi_requester.sv
// N-channel AHB-Lite requester: round-robin arbitration of payload-wide go/done requests,
// each executed as one INCR burst of word beats with wait-state and ERROR handling.
module mcse_ahb_multi_requester #(
  parameter int unsigned N_REQ              = 2,
  parameter int unsigned pAHB_ADDR_WIDTH    = 32,
  parameter int unsigned pAHB_DATA_WIDTH    = 32,
  parameter int unsigned pPAYLOAD_SIZE_BITS = 256,
  parameter int unsigned pAHB_HRESP_WIDTH   = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_REQ-1:0]                      req_go,
  input  logic [N_REQ*pAHB_ADDR_WIDTH-1:0]      req_addr,
  input  logic [N_REQ*pPAYLOAD_SIZE_BITS-1:0]   req_wdata,
  input  logic [N_REQ-1:0]                      req_rw,
  output logic [N_REQ-1:0]                      req_done,
  output logic                                  req_err,
  output logic [pPAYLOAD_SIZE_BITS-1:0]         req_rdata,
  input  logic [pAHB_DATA_WIDTH-1:0]            I_hrdata,
  input  logic                                  I_hready,
  input  logic [pAHB_HRESP_WIDTH-1:0]           I_hresp,
  input  logic                                  I_hreadyout,
  output logic [pAHB_ADDR_WIDTH-1:0]            O_haddr,
  output logic [2:0]                            O_hburst,
  output logic                                  O_hmastlock,
  output logic [3:0]                            O_hprot,
  output logic                                  O_hnonsec,
  output logic [2:0]                            O_hsize,
  output logic [1:0]                            O_htrans,
  output logic [pAHB_DATA_WIDTH-1:0]            O_hwdata,
  output logic                                  O_hwrite
);

  localparam int unsigned AW    = pAHB_ADDR_WIDTH;
  localparam int unsigned DW    = pAHB_DATA_WIDTH;
  localparam int unsigned PW    = pPAYLOAD_SIZE_BITS;
  localparam int unsigned BEATS = PW / DW;
  localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW    = $clog2(BEATS + 1);
  localparam int unsigned OFFW  = $clog2(PW / 8);

  localparam logic [IW-1:0] LAST_CH   = IW'(N_REQ - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [AW-1:0] AMASK     = {AW{1'b1}} << OFFW;
  localparam logic [pAHB_HRESP_WIDTH-1:0] HRESP_OKAY = '0;
  localparam logic [pAHB_HRESP_WIDTH-1:0] HRESP_ERR  = pAHB_HRESP_WIDTH'(1);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [PW-1:0]   wdata_q, wdata_d;
  logic            rw_q, rw_d;
  logic            err_q, err_d;
  logic [CW-1:0]   beat_q, beat_d;
  logic [PW-1:0]   rbuf_q, rbuf_d;
  logic [PW-1:0]   rdo_q, rdo_d;

  logic            found, hi_found, lo_found;
  logic [IW-1:0]   sel, hi_sel, lo_sel;
  logic [CW-1:0]   didx;
  logic            cap;
  logic            unused_hreadyout;

  assign unused_hreadyout = I_hreadyout;
  assign didx             = beat_q - 1'b1;

  assign O_hburst    = 3'b001;
  assign O_hsize     = 3'b010;
  assign O_hprot     = 4'b0011;
  assign O_hmastlock = 1'b0;
  assign O_hnonsec   = 1'b1;

  // Round robin: first go at or above the pointer, otherwise wrap to the lowest asserted go.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_sel   = '0;
    lo_sel   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_go[i] && !hi_found && (IW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_sel   = IW'(i);
      end
      if (req_go[i] && !lo_found) begin
        lo_found = 1'b1;
        lo_sel   = IW'(i);
      end
    end
    found = hi_found | lo_found;
    sel   = hi_found ? hi_sel : lo_sel;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    err_d     = err_q;
    beat_d    = beat_q;
    rbuf_d    = rbuf_q;
    rdo_d     = rdo_q;
    cap       = 1'b0;
    O_htrans  = HT_IDLE;
    O_haddr   = '0;
    O_hwrite  = 1'b0;
    O_hwdata  = '0;
    req_done  = '0;
    req_err   = 1'b0;
    req_rdata = rdo_q;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_ADDR;
          grant_d = sel;
          ptr_d   = (sel == LAST_CH) ? '0 : sel + 1'b1;
          addr_d  = req_addr[sel*AW +: AW] & AMASK;
          wdata_d = req_wdata[sel*PW +: PW];
          rw_d    = req_rw[sel];
          err_d   = 1'b0;
          beat_d  = '0;
        end
      end
      S_ADDR: begin
        O_htrans = (beat_q == '0) ? HT_NONSEQ : HT_SEQ;
        O_haddr  = addr_q + (AW'(beat_q) << 2);
        O_hwrite = rw_q;
        if (beat_q != '0) O_hwdata = wdata_q[didx*DW +: DW];
        // An ERROR can only answer an outstanding data phase, so beat 0 ignores hresp.
        if ((beat_q != '0) && !I_hready && (I_hresp == HRESP_ERR)) begin
          err_d   = 1'b1;
          state_d = S_DATA;
        end else if (I_hready) begin
          cap    = (beat_q != '0);
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) state_d = S_DATA;
        end
      end
      S_DATA: begin
        O_hwdata = wdata_q[didx*DW +: DW];
        if (I_hready) begin
          cap     = 1'b1;
          state_d = S_DONE;
        end else if (I_hresp == HRESP_ERR) begin
          err_d = 1'b1;
        end
      end
      S_DONE: begin
        req_done  = N_REQ'(1) << grant_q;
        req_err   = err_q;
        req_rdata = rbuf_q;
        rdo_d     = rbuf_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cap && !rw_q && !err_q && (I_hresp == HRESP_OKAY))
      rbuf_d[didx*DW +: DW] = I_hrdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      rbuf_q  <= '0;
      rdo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      rbuf_q  <= rbuf_d;
      rdo_q   <= rdo_d;
    end
  end

endmodule
